// File: rtl/packet_deframer.sv
// Serial RX deframer: hunts for a 16-bit sync word, then shifts in one fixed-size
// packet MSB first and presents it with a one-cycle ready pulse.
module packet_deframer #(
    parameter logic [15:0] SYNC_WORD   = 16'hA5C3,
    parameter int          PACKET_BITS = 288,
    parameter int          TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_bit,
    input  logic                   rx_valid,
    output logic [PACKET_BITS-1:0] packet,
    output logic                   ready,
    output logic                   busy,
    output logic [15:0]            frames_received,
    output logic [15:0]            frames_aborted
);

    localparam int CNT_W  = $clog2(PACKET_BITS + 1);
    localparam int IDLE_W = $clog2(TIMEOUT);

    typedef enum logic {HUNT, RECEIVE} state_t;

    state_t                 state_q, state_d;
    logic [15:0]            sync_sr_q, sync_sr_d;
    logic [PACKET_BITS-1:0] pay_sr_q, pay_sr_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [IDLE_W-1:0]      idle_cnt_q, idle_cnt_d;
    logic [PACKET_BITS-1:0] packet_q, packet_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic [15:0]            frames_received_q, frames_received_d;
    logic [15:0]            frames_aborted_q, frames_aborted_d;

    logic [15:0]            sync_next;
    logic [PACKET_BITS-1:0] pay_next;

    assign sync_next = {sync_sr_q[14:0], rx_bit};
    assign pay_next  = {pay_sr_q[PACKET_BITS-2:0], rx_bit};

    always_comb begin
        state_d           = state_q;
        sync_sr_d         = sync_sr_q;
        pay_sr_d          = pay_sr_q;
        bit_cnt_d         = bit_cnt_q;
        idle_cnt_d        = idle_cnt_q;
        packet_d          = packet_q;
        ready_d           = 1'b0;
        frames_received_d = frames_received_q;
        frames_aborted_d  = frames_aborted_q;
        unique case (state_q)
            HUNT: begin
                if (rx_valid) begin
                    if (sync_next == SYNC_WORD) begin
                        state_d    = RECEIVE;
                        bit_cnt_d  = '0;
                        idle_cnt_d = '0;
                        sync_sr_d  = '0;
                    end else begin
                        sync_sr_d = sync_next;
                    end
                end
            end
            RECEIVE: begin
                if (rx_valid) begin
                    // a bit arriving on the timeout cycle still counts
                    pay_sr_d   = pay_next;
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    idle_cnt_d = '0;
                    if (bit_cnt_q == CNT_W'(PACKET_BITS - 1)) begin
                        packet_d  = pay_next;
                        ready_d   = 1'b1;
                        state_d   = HUNT;
                        sync_sr_d = '0;
                        if (frames_received_q != 16'hFFFF)
                            frames_received_d = frames_received_q + 16'd1;
                    end
                end else if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
                    state_d  = HUNT;
                    pay_sr_d = '0;
                    if (frames_aborted_q != 16'hFFFF)
                        frames_aborted_d = frames_aborted_q + 16'd1;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase
        busy_d = (state_d == RECEIVE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= HUNT;
            sync_sr_q         <= '0;
            pay_sr_q          <= '0;
            bit_cnt_q         <= '0;
            idle_cnt_q        <= '0;
            packet_q          <= '0;
            ready_q           <= 1'b0;
            busy_q            <= 1'b0;
            frames_received_q <= '0;
            frames_aborted_q  <= '0;
        end else begin
            state_q           <= state_d;
            sync_sr_q         <= sync_sr_d;
            pay_sr_q          <= pay_sr_d;
            bit_cnt_q         <= bit_cnt_d;
            idle_cnt_q        <= idle_cnt_d;
            packet_q          <= packet_d;
            ready_q           <= ready_d;
            busy_q            <= busy_d;
            frames_received_q <= frames_received_d;
            frames_aborted_q  <= frames_aborted_d;
        end
    end

    assign packet          = packet_q;
    assign ready           = ready_q;
    assign busy            = busy_q;
    assign frames_received = frames_received_q;
    assign frames_aborted  = frames_aborted_q;

endmodule
